// File: rtl/esl_clk_check_pkg.sv
// Shared types and constants for the CUT frequency-check sequencer.
package esl_clk_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_REQ = 3'd1,
    ST_RST_REL = 3'd2,
    ST_COUNT   = 3'd3,
    ST_STOP    = 3'd4,
    ST_STORE   = 3'd5,
    ST_CMP     = 3'd6
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 1024;

  // CUT count width: one guard bit above BIT_WD, matching the counter.
  function automatic int unsigned cnt_wd(input int unsigned bit_wd);
    return bit_wd + 1;
  endfunction

endpackage

// File: rtl/esl_clk_check_dntimer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module esl_clk_check_dntimer #(
  parameter int unsigned WD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [WD-1:0] load_val,
  output logic          expired_c
);

  logic [WD-1:0] cnt_q;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WD'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/esl_clk_check_seq.sv
// Reference-domain sequencer for the CUT frequency checker: drives the
// counter controls over one window, runs both CDC handshakes and compares
// the stored count against the limits.
// Optional handshake timeout: define ESL_CLK_CHECK_TIMEOUT_EN.
module esl_clk_check_seq
  import esl_clk_check_pkg::*;
#(
  parameter int unsigned BIT_WD      = 24,
  parameter int unsigned WIN_WD      = 16,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      ref_clk,
  input  logic                      ref_rst_n,
  input  logic                      check_start,
  input  logic                      check_continuous,
  input  logic [WIN_WD-1:0]         ref_window,
  input  logic [cnt_wd(BIT_WD)-1:0] cut_count_min,
  input  logic [cnt_wd(BIT_WD)-1:0] cut_count_max,
  input  logic                      reset_ack,
  input  logic                      cut_count_available,
  input  logic [cnt_wd(BIT_WD)-1:0] cut_count_store,
  output logic                      reset_cut_count,
  output logic                      en_cut_count,
  output logic                      en_flag_gen,
  output logic                      check_busy,
  output logic                      check_done,
  output logic                      clk_fail,
  output logic                      fail_low,
  output logic                      fail_high,
  output logic                      stuck_fault
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t              state_q, state_d;
  logic                seen_low_q, seen_low_d, seen_low_c;
  logic                win_load_c, win_exp_c;
  logic [WIN_WD-1:0]   win_val_c;
  logic                fail_low_d, fail_high_d, clk_fail_d, stuck_d, done_d;

  // Window of 0 behaves as 1: timer holds window-1 so expiry marks the last cycle.
  assign win_val_c  = (ref_window == '0) ? '0 : ref_window - WIN_WD'(1);
  assign seen_low_c = seen_low_q | ~cut_count_available;

  esl_clk_check_dntimer #(.WD(WIN_WD)) u_win_timer (
    .clk       (ref_clk),
    .rst_n     (ref_rst_n),
    .load      (win_load_c),
    .load_val  (win_val_c),
    .expired_c (win_exp_c)
  );

`ifdef ESL_CLK_CHECK_TIMEOUT_EN
  localparam int unsigned TMO_WD = $clog2(TIMEOUT_CYC + 1);

  logic tmo_load_c, tmo_exp_c, tmo_watch_c;
  logic win_end_q, win_end_d;

  esl_clk_check_dntimer #(.WD(TMO_WD)) u_tmo_timer (
    .clk       (ref_clk),
    .rst_n     (ref_rst_n),
    .load      (tmo_load_c),
    .load_val  (TMO_WD'(TIMEOUT_CYC)),
    .expired_c (tmo_exp_c)
  );
`endif

  // Next-state, sticky seen_low and result decisions.
  always_comb begin
    state_d     = state_q;
    seen_low_d  = seen_low_q;
    win_load_c  = 1'b0;
    fail_low_d  = fail_low;
    fail_high_d = fail_high;
    clk_fail_d  = clk_fail;
    stuck_d     = stuck_fault;
    done_d      = 1'b0;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    tmo_load_c  = 1'b0;
    win_end_d   = win_end_q;
    tmo_watch_c = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (check_start) begin
          state_d     = ST_RST_REQ;
          fail_low_d  = 1'b0;
          fail_high_d = 1'b0;
          clk_fail_d  = 1'b0;
          stuck_d     = 1'b0;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
          tmo_load_c  = 1'b1;
`endif
        end
      end
      ST_RST_REQ: begin
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
        tmo_watch_c = 1'b1;
`endif
        if (reset_ack) begin
          state_d = ST_RST_REL;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
          tmo_load_c = 1'b1;
`endif
        end
      end
      ST_RST_REL: begin
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
        tmo_watch_c = 1'b1;
        win_end_d   = 1'b0;
`endif
        if (!reset_ack) begin
          state_d    = ST_COUNT;
          win_load_c = 1'b1;
          seen_low_d = 1'b0;
        end
      end
      ST_COUNT: begin
        seen_low_d = seen_low_c;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
        tmo_watch_c = win_end_q;
`endif
        if (win_exp_c) begin
          if (seen_low_c) begin
            state_d = ST_STOP;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
            tmo_load_c = 1'b1;
`endif
          end
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
          else if (!win_end_q) begin
            win_end_d  = 1'b1;
            tmo_load_c = 1'b1;
          end
`endif
        end
      end
      ST_STOP: begin
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
        tmo_watch_c = 1'b1;
`endif
        if (cut_count_available) state_d = ST_STORE;
      end
      ST_STORE: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        fail_low_d  = (cut_count_store < cut_count_min);
        fail_high_d = (cut_count_store > cut_count_max);
        clk_fail_d  = fail_low_d | fail_high_d;
        stuck_d     = 1'b0;
        done_d      = 1'b1;
        if (check_continuous) begin
          state_d = ST_RST_REQ;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
          tmo_load_c = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    // An expired handshake wait aborts straight to IDLE with a fault.
    if (tmo_watch_c && tmo_exp_c) begin
      state_d    = ST_IDLE;
      stuck_d    = 1'b1;
      clk_fail_d = 1'b1;
      done_d     = 1'b1;
      tmo_load_c = 1'b0;
    end
`endif
  end

  // State, sticky flags and registered outputs derived from the next state.
  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state_q         <= ST_IDLE;
      seen_low_q      <= 1'b0;
      reset_cut_count <= 1'b0;
      en_cut_count    <= 1'b0;
      en_flag_gen     <= 1'b0;
      check_busy      <= 1'b0;
      check_done      <= 1'b0;
      clk_fail        <= 1'b0;
      fail_low        <= 1'b0;
      fail_high       <= 1'b0;
      stuck_fault     <= 1'b0;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
      win_end_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      seen_low_q      <= seen_low_d;
      reset_cut_count <= (state_d == ST_RST_REQ);
      en_cut_count    <= (state_d == ST_COUNT);
      en_flag_gen     <= (state_d == ST_STORE);
      check_busy      <= (state_d != ST_IDLE);
      check_done      <= done_d;
      clk_fail        <= clk_fail_d;
      fail_low        <= fail_low_d;
      fail_high       <= fail_high_d;
      stuck_fault     <= stuck_d;
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
      win_end_q       <= win_end_d;
`endif
    end
  end

endmodule

// File: tb/tb_esl_clk_check_seq.sv
// Bench for esl_clk_check_seq with a behavioural CUT counter and CDC syncs.
module tb_esl_clk_check_seq;

  typedef struct {
    logic fl;
    logic fh;
    int   cyc;
  } exp_t;

  logic        ref_clk = 1'b0;
  logic        ref_rst_n;
  logic        check_start, check_continuous;
  logic [15:0] ref_window;
  logic [24:0] cut_count_min, cut_count_max, cut_count_store;
  logic        reset_ack, cut_count_available;
  logic        reset_cut_count, en_cut_count, en_flag_gen, check_busy, check_done;
  logic        clk_fail, fail_low, fail_high, stuck_fault;

  esl_clk_check_seq #(.BIT_WD(24), .WIN_WD(16), .TIMEOUT_CYC(256)) dut (
    .ref_clk             (ref_clk),
    .ref_rst_n           (ref_rst_n),
    .check_start         (check_start),
    .check_continuous    (check_continuous),
    .ref_window          (ref_window),
    .cut_count_min       (cut_count_min),
    .cut_count_max       (cut_count_max),
    .reset_ack           (reset_ack),
    .cut_count_available (cut_count_available),
    .cut_count_store     (cut_count_store),
    .reset_cut_count     (reset_cut_count),
    .en_cut_count        (en_cut_count),
    .en_flag_gen         (en_flag_gen),
    .check_busy          (check_busy),
    .check_done          (check_done),
    .clk_fail            (clk_fail),
    .fail_low            (fail_low),
    .fail_high           (fail_high),
    .stuck_fault         (stuck_fault)
  );

  initial forever #30 ref_clk = ~ref_clk;

  // CUT clock: half period in time units; can be stopped.
  logic cut_clk  = 1'b0;
  int   cut_half = 15;
  bit   cut_run  = 1'b1;
  initial forever begin
    if (cut_run) #(cut_half) cut_clk = ~cut_clk;
    else #10;
  end

  // CUT-side counter model with two-flop syncs in both directions.
  logic [1:0]  rs_cut = '0, en_cut = '0, ack_s = '0, av_s = 2'b11;
  logic [24:0] cnt = '0, store_q = '0;
  always @(posedge cut_clk) begin
    rs_cut <= {rs_cut[0], reset_cut_count};
    en_cut <= {en_cut[0], en_cut_count};
    if (rs_cut[1]) cnt <= '0;
    else if (en_cut[1]) cnt <= cnt + 25'd1;
  end
  always @(posedge ref_clk) begin
    ack_s <= {ack_s[0], rs_cut[1]};
    av_s  <= {av_s[0], ~en_cut[1]};
    if (en_flag_gen) store_q <= cnt;
  end
  assign reset_ack           = ack_s[1];
  assign cut_count_available = av_s[1];
  assign cut_count_store     = store_q;

  // Monitor: cycle count, activity totals and scoreboard pushes.
  int   cyc = 0, done_total = 0, en_total = 0, low_total = 0;
  logic pend = 1'b0;
  exp_t exp_q[$];
  always @(posedge ref_clk) cyc <= cyc + 1;
  always @(negedge ref_clk) begin
    if (pend)
      exp_q.push_back('{fl: (cut_count_store < cut_count_min),
                        fh: (cut_count_store > cut_count_max), cyc: cyc + 1});
    pend <= en_flag_gen;
    if (check_done) done_total <= done_total + 1;
    if (en_cut_count) en_total <= en_total + 1;
    if (en_cut_count && !cut_count_available) low_total <= low_total + 1;
  end

  int n_chk = 0, n_pass = 0, rd_idx = 0;

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      if (check_done === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_en(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      if (en_cut_count === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic pulse_start();
    check_start = 1'b1;
    @(negedge ref_clk);
    check_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    ref_rst_n = 1'b0;
    repeat (3) @(negedge ref_clk);
    obs = {reset_cut_count, en_cut_count, en_flag_gen, check_busy, check_done,
           clk_fail, fail_low, fail_high, stuck_fault};
    n_chk++;
    if (obs !== 9'b0) $display("FAIL reset_outputs: got %b want 000000000", obs);
    else n_pass++;
    ref_rst_n = 1'b1;
    repeat (3) @(negedge ref_clk);
    n_chk++;
    if (check_busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", check_busy);
    else n_pass++;
  endtask

  task automatic test_limits(input string nm, input int half, input bit xfl, input bit xfh);
    bit got;
    exp_t e;
    int e0, d0, lo, hi;
    cut_half = half;
    lo = (30 / half) * 1000 - 5;
    hi = (30 / half) * 1000 + 5;
    ref_window = 16'd1000; cut_count_min = 25'd1990; cut_count_max = 25'd2010;
    check_continuous = 1'b0;
    repeat (6) @(negedge ref_clk);
    e0 = en_total; d0 = done_total;
    pulse_start();
    n_chk++;
    if ({check_busy, reset_cut_count} !== 2'b11)
      $display("FAIL %s start_latency: busy,rst=%b want 11", nm, {check_busy, reset_cut_count});
    else n_pass++;
    wait_done(1200, got);
    n_chk++;
    if (!got) $display("FAIL %s done_timeout: no check_done within 1200 cycles", nm);
    else n_pass++;
    n_chk++;
    if (rd_idx >= exp_q.size()) $display("FAIL %s scoreboard: no expected result queued", nm);
    else begin
      e = exp_q[rd_idx]; rd_idx++;
      if ({fail_low, fail_high, clk_fail} !== {e.fl, e.fh, e.fl | e.fh} || cyc != e.cyc)
        $display("FAIL %s scoreboard: flags=%b cyc=%0d want flags=%b cyc=%0d", nm,
                 {fail_low, fail_high, clk_fail}, cyc, {e.fl, e.fh, e.fl | e.fh}, e.cyc);
      else n_pass++;
    end
    n_chk++;
    if ({fail_low, fail_high, clk_fail} !== {xfl, xfh, xfl | xfh})
      $display("FAIL %s verdict: low,high,fail=%b want %b", nm,
               {fail_low, fail_high, clk_fail}, {xfl, xfh, xfl | xfh});
    else n_pass++;
    n_chk++;
    if (int'(cut_count_store) < lo || int'(cut_count_store) > hi)
      $display("FAIL %s count_range: store=%0d want %0d..%0d", nm, cut_count_store, lo, hi);
    else n_pass++;
    n_chk++;
    if (en_total - e0 != 1000)
      $display("FAIL %s window_len: en cycles=%0d want 1000", nm, en_total - e0);
    else n_pass++;
    @(negedge ref_clk);
    n_chk++;
    if (done_total - d0 != 1 || check_busy !== 1'b0)
      $display("FAIL %s done_once: dones=%0d busy=%b want 1 and 0", nm, done_total - d0, check_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got;
    exp_t e;
    int d0;
    cut_half = 15;
    ref_window = 16'd50; cut_count_min = 25'd90; cut_count_max = 25'd110;
    check_continuous = 1'b1;
    repeat (6) @(negedge ref_clk);
    d0 = done_total;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        wait_en(100, got);
        n_chk++;
        if (!got) $display("FAIL cont en_timeout: third window never started");
        else n_pass++;
        check_continuous = 1'b0;
      end
      wait_done(300, got);
      n_chk++;
      if (!got) $display("FAIL cont done_timeout: result %0d missing", k);
      else n_pass++;
      n_chk++;
      if (rd_idx >= exp_q.size()) $display("FAIL cont scoreboard: no expected result %0d", k);
      else begin
        e = exp_q[rd_idx]; rd_idx++;
        if ({fail_low, fail_high, clk_fail} !== {e.fl, e.fh, e.fl | e.fh} || cyc != e.cyc)
          $display("FAIL cont scoreboard: result %0d flags=%b cyc=%0d want flags=%b cyc=%0d", k,
                   {fail_low, fail_high, clk_fail}, cyc, {e.fl, e.fh, e.fl | e.fh}, e.cyc);
        else n_pass++;
      end
      n_chk++;
      if (check_busy !== (k < 2))
        $display("FAIL cont rearm: result %0d busy=%b want %b", k, check_busy, (k < 2));
      else n_pass++;
    end
    repeat (20) @(negedge ref_clk);
    n_chk++;
    if (done_total - d0 != 3 || check_busy !== 1'b0)
      $display("FAIL cont stop: dones=%0d busy=%b want 3 and 0", done_total - d0, check_busy);
    else n_pass++;
  endtask

  task automatic test_zero_window();
    bit got;
    exp_t e;
    int e0, l0;
    cut_half = 15;
    ref_window = 16'd0; cut_count_min = 25'd0; cut_count_max = '1;
    check_continuous = 1'b0;
    repeat (6) @(negedge ref_clk);
    e0 = en_total; l0 = low_total;
    pulse_start();
    wait_done(100, got);
    n_chk++;
    if (!got) $display("FAIL win0 done_timeout: no check_done within 100 cycles");
    else n_pass++;
    n_chk++;
    if (rd_idx >= exp_q.size()) $display("FAIL win0 scoreboard: no expected result queued");
    else begin
      e = exp_q[rd_idx]; rd_idx++;
      if ({fail_low, fail_high, clk_fail} !== {e.fl, e.fh, e.fl | e.fh} || cyc != e.cyc)
        $display("FAIL win0 scoreboard: flags=%b cyc=%0d want flags=%b cyc=%0d",
                 {fail_low, fail_high, clk_fail}, cyc, {e.fl, e.fh, e.fl | e.fh}, e.cyc);
      else n_pass++;
    end
    n_chk++;
    if (en_total - e0 < 2 || low_total - l0 != 1)
      $display("FAIL win0 hold_until_low: en cycles=%0d low overlap=%0d want >=2 and 1",
               en_total - e0, low_total - l0);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    bit got;
    exp_t e;
    int d0;
    cut_half = 15;
    ref_window = 16'd100; cut_count_min = 25'd190; cut_count_max = 25'd210;
    check_continuous = 1'b0;
    repeat (6) @(negedge ref_clk);
    d0 = done_total;
    pulse_start();
    wait_en(50, got);
    n_chk++;
    if (!got) $display("FAIL busy en_timeout: window never started");
    else n_pass++;
    repeat (5) @(negedge ref_clk);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ref_clk);
      if (en_flag_gen === 1'b1) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL busy store_timeout: en_flag_gen never seen");
    else n_pass++;
    @(negedge ref_clk);
    check_start = 1'b1;
    @(negedge ref_clk);
    check_start = 1'b0;
    n_chk++;
    if (check_done !== 1'b1) $display("FAIL busy done_latency: done=%b want 1", check_done);
    else n_pass++;
    n_chk++;
    if (rd_idx >= exp_q.size()) $display("FAIL busy scoreboard: no expected result queued");
    else begin
      e = exp_q[rd_idx]; rd_idx++;
      if ({fail_low, fail_high, clk_fail} !== {e.fl, e.fh, e.fl | e.fh} || cyc != e.cyc)
        $display("FAIL busy scoreboard: flags=%b cyc=%0d want flags=%b cyc=%0d",
                 {fail_low, fail_high, clk_fail}, cyc, {e.fl, e.fh, e.fl | e.fh}, e.cyc);
      else n_pass++;
    end
    repeat (10) @(negedge ref_clk);
    n_chk++;
    if (done_total - d0 != 1 || check_busy !== 1'b0)
      $display("FAIL busy ignored_starts: dones=%0d busy=%b want 1 and 0", done_total - d0, check_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [8:0] obs;
    ref_window = 16'd200; cut_count_min = 25'd0; cut_count_max = 25'd0;
    repeat (6) @(negedge ref_clk);
    pulse_start();
    wait_en(50, got);
    n_chk++;
    if (!got) $display("FAIL rstmid en_timeout: window never started");
    else n_pass++;
    repeat (10) @(negedge ref_clk);
    #5 ref_rst_n = 1'b0;
    #1;
    obs = {reset_cut_count, en_cut_count, en_flag_gen, check_busy, check_done,
           clk_fail, fail_low, fail_high, stuck_fault};
    n_chk++;
    if (obs !== 9'b0) $display("FAIL rstmid async_clear: got %b want 000000000", obs);
    else n_pass++;
    repeat (3) @(negedge ref_clk);
    ref_rst_n = 1'b1;
    repeat (10) @(negedge ref_clk);
    n_chk++;
    if ({check_busy, en_cut_count} !== 2'b00)
      $display("FAIL rstmid idle_after: busy,en=%b want 00", {check_busy, en_cut_count});
    else n_pass++;
  endtask

`ifdef ESL_CLK_CHECK_TIMEOUT_EN
  task automatic test_stuck();
    bit got;
    int c0;
    ref_window = 16'd100; cut_count_min = 25'd0; cut_count_max = '1;
    check_continuous = 1'b1;
    repeat (10) @(negedge ref_clk);
    cut_run = 1'b0;
    repeat (4) @(negedge ref_clk);
    pulse_start();
    c0 = cyc;
    wait_done(300, got);
    n_chk++;
    if (!got) $display("FAIL stuck done_timeout: no check_done within 300 cycles");
    else n_pass++;
    n_chk++;
    if (cyc - c0 < 256 || cyc - c0 > 260)
      $display("FAIL stuck latency: %0d cycles from RST_REQ want 256..260", cyc - c0);
    else n_pass++;
    n_chk++;
    if ({stuck_fault, clk_fail, fail_low, fail_high} !== 4'b1100)
      $display("FAIL stuck flags: stuck,fail,low,high=%b want 1100",
               {stuck_fault, clk_fail, fail_low, fail_high});
    else n_pass++;
    @(negedge ref_clk);
    n_chk++;
    if ({check_busy, reset_cut_count, en_cut_count} !== 3'b000)
      $display("FAIL stuck abort_idle: busy,rst,en=%b want 000",
               {check_busy, reset_cut_count, en_cut_count});
    else n_pass++;
    check_continuous = 1'b0;
    cut_run = 1'b1;
  endtask
`endif

  initial begin
    ref_rst_n = 1'b0; check_start = 1'b0; check_continuous = 1'b0;
    ref_window = '0; cut_count_min = '0; cut_count_max = '0;
    test_reset();
    test_limits("pass", 15, 1'b0, 1'b0);
    test_limits("slow", 30, 1'b1, 1'b0);
    test_limits("fast", 10, 1'b0, 1'b1);
    test_back_to_back();
    test_zero_window();
    test_start_busy();
    test_reset_mid();
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    test_stuck();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
